leaf_out_arbiter: RTL



---
 rtl/leaf_pkt_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 26 ++
 rtl/leaf_out_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/leaf_pkt_pkg.sv
// Leaf-to-BFT packet layout shared by the leaf interface blocks.
package leaf_pkt_pkg;
  localparam int LEAF_PAYLOAD_BITS = 32;
  localparam int LEAF_LEAF_BITS    = 5;
  localparam int LEAF_PORT_BITS    = 4;
  localparam int LEAF_ADDR_BITS    = 7;
  localparam int LEAF_PACKET_BITS  = 1 + LEAF_LEAF_BITS + LEAF_PORT_BITS + LEAF_ADDR_BITS + LEAF_PAYLOAD_BITS;

  localparam int PKT_PAYLOAD_LSB = 0;
  localparam int PKT_ADDR_LSB    = PKT_PAYLOAD_LSB + LEAF_PAYLOAD_BITS;
  localparam int PKT_PORT_LSB    = PKT_ADDR_LSB + LEAF_ADDR_BITS;
  localparam int PKT_LEAF_LSB    = PKT_PORT_LSB + LEAF_PORT_BITS;
  localparam int PKT_VLD_BIT     = PKT_LEAF_LSB + LEAF_LEAF_BITS;

  typedef struct packed {
    logic                         vld;
    logic [LEAF_LEAF_BITS-1:0]    leaf;
    logic [LEAF_PORT_BITS-1:0]    port;
    logic [LEAF_ADDR_BITS-1:0]    addr;
    logic [LEAF_PAYLOAD_BITS-1:0] payload;
  } leaf_pkt_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past ptr_i, first requester wins.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  // rotating priority search
  always_comb begin
    int   idx;
    logic found;
    gnt_o = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Credit-checked round-robin scheduler of user output streams onto the leaf-to-BFT port.
// Optional per-port grant counters are enabled by defining LEAF_OUT_ARB_STATS_EN.
module leaf_out_arbiter
  import leaf_pkt_pkg::*;
#(
  parameter int PACKET_BITS           = LEAF_PACKET_BITS,
  parameter int PAYLOAD_BITS          = LEAF_PAYLOAD_BITS,
  parameter int NUM_LEAF_BITS         = LEAF_LEAF_BITS,
  parameter int NUM_PORT_BITS         = LEAF_PORT_BITS,
  parameter int NUM_ADDR_BITS         = LEAF_ADDR_BITS,
  parameter int NUM_OUT_PORTS         = 5,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  input  logic                                  cfg_wr,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port,
  input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0] cfg_dest,
  input  logic                                  fs_vld,
  input  logic [NUM_PORT_BITS-1:0]              fs_port,
  input  logic                                  resend,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
  output logic                                  credit_err
`ifdef LEAF_OUT_ARB_STATS_EN
  ,
  input  logic [NUM_PORT_BITS-1:0]              stat_sel,
  output logic [31:0]                           stat_cnt
`endif
);

  localparam int DEST_W = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int CRED_W = NUM_ADDR_BITS + 1;
  localparam int PTR_W  = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam logic [CRED_W:0] CRED_LIM = (CRED_W+1)'(2**NUM_ADDR_BITS);
  localparam logic [CRED_W:0] FS_INC   = (CRED_W+1)'(FREESPACE_UPDATE_SIZE);

  logic [CRED_W-1:0]        credit_q   [NUM_OUT_PORTS];
  logic [CRED_W-1:0]        credit_d   [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] wptr_q     [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] wptr_d     [NUM_OUT_PORTS];
  logic [DEST_W-1:0]        dest_q     [NUM_OUT_PORTS];
  logic [DEST_W-1:0]        dest_d     [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] dest_vld_q, dest_vld_d;
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [PACKET_BITS-1:0]   pkt_q, pkt_d;
  logic                     err_q, err_d;
  logic [NUM_OUT_PORTS-1:0] req_s, gnt_s;
  logic                     fs_ok_s, cfg_ok_s;

  assign fs_ok_s  = int'(fs_port) < NUM_OUT_PORTS;
  assign cfg_ok_s = int'(cfg_port) < NUM_OUT_PORTS;

  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      req_s[i] = vld_user2interface[i] && (credit_q[i] != '0) && dest_vld_q[i] && !resend;
    end
  end

  rr_arbiter #(.N(NUM_OUT_PORTS), .PTR_W(PTR_W)) u_rr (
    .req_i (req_s),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt_s)
  );

  assign ack_interface2user = gnt_s;
  // the held packet stays registered during resend; only its valid bit is masked
  assign dout_leaf_interface2bft = {pkt_q[PACKET_BITS-1] & ~resend, pkt_q[PACKET_BITS-2:0]};
  assign credit_err = err_q;

  always_comb begin
    logic [CRED_W:0] sum;
    credit_d   = credit_q;
    wptr_d     = wptr_q;
    dest_d     = dest_q;
    dest_vld_d = dest_vld_q;
    rr_ptr_d   = rr_ptr_q;
    pkt_d      = resend ? pkt_q : '0;
    err_d      = err_q | (fs_vld & ~fs_ok_s) | (cfg_wr & ~cfg_ok_s);
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      sum = {1'b0, credit_q[i]};
      sum = (fs_vld && fs_ok_s && (int'(fs_port) == i)) ? sum + FS_INC : sum;
      sum = gnt_s[i] ? sum - (CRED_W+1)'(1) : sum;
      if (sum > CRED_LIM) begin
        credit_d[i] = CRED_LIM[CRED_W-1:0];
        err_d       = 1'b1;
      end else begin
        credit_d[i] = sum[CRED_W-1:0];
      end
      // grant reads dest_q, so a same-cycle cfg write only affects later packets
      if (gnt_s[i]) begin
        pkt_d     = {1'b1, dest_q[i], wptr_q[i], din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
        wptr_d[i] = wptr_q[i] + NUM_ADDR_BITS'(1);
        rr_ptr_d  = PTR_W'(i);
      end
      if (cfg_wr && cfg_ok_s && (int'(cfg_port) == i)) begin
        dest_d[i]     = cfg_dest;
        dest_vld_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_q[i] <= CRED_LIM[CRED_W-1:0];
        wptr_q[i]   <= '0;
        dest_q[i]   <= '0;
      end
      dest_vld_q <= '0;
      rr_ptr_q   <= PTR_W'(NUM_OUT_PORTS - 1);
      pkt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      credit_q   <= credit_d;
      wptr_q     <= wptr_d;
      dest_q     <= dest_d;
      dest_vld_q <= dest_vld_d;
      rr_ptr_q   <= rr_ptr_d;
      pkt_q      <= pkt_d;
      err_q      <= err_d;
    end
  end

`ifdef LEAF_OUT_ARB_STATS_EN
  logic [31:0] stat_q [NUM_OUT_PORTS];
  logic [31:0] stat_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        stat_q[i] <= '0;
      end
      stat_cnt_q <= '0;
    end else begin
      stat_cnt_q <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (gnt_s[i]) begin
          stat_q[i] <= stat_q[i] + 32'd1;
        end
        if (int'(stat_sel) == i) begin
          stat_cnt_q <= stat_q[i];
        end
      end
    end
  end

  assign stat_cnt = stat_cnt_q;
`endif

endmodule
